// File: rtl/proc_io_pkg.sv
// proc_io_pkg: shared widths, port-index constants and pointer-width helper for the output collector
package proc_io_pkg;
    localparam int NB_DEF         = 32;
    localparam int NOUT_DEF       = 7;
    localparam int DEPTH_DEF      = 4;
    localparam int IN_PORT        = 0;
    localparam int FIRST_OUT_PORT = 1;
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/out_port_fifo.sv
// out_port_fifo: single first-word-fall-through FIFO for one processor output port
//   clk, rst      clock, synchronous active-high reset
//   push_i/data_i write request and word
//   pop_i         consume head (ignored while empty)
//   full_o/empty_o occupancy flags
//   head_o        head word, 0 while empty
module out_port_fifo
    import proc_io_pkg::*;
#(
    parameter int NB    = NB_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [NB-1:0] data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [NB-1:0] head_o
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    logic [NB-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];
    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop_i && !empty_o;
        push_ok = push_i && (!full_o || pop_ok);
        wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop_ok ? rptr_q + PW'(1) : rptr_q;
        cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/proc_out_collector.sv
// proc_out_collector: decodes the processor output strobe and buffers words per output port
//   clk, rst     clock, synchronous active-high reset
//   proc_io_out  output word;  proc_out_en  one-hot port strobe (bit 0 = input port)
//   out_data/out_valid/out_ready  per-port stream, slice p-1 = port p
//   overflow     sticky per-port drop flag;  dec_err  sticky illegal-strobe flag
//   err_clr      clears both sticky flags (a same-cycle new error wins)
module proc_out_collector
    import proc_io_pkg::*;
#(
    parameter int NB    = NB_DEF,
    parameter int NOUT  = NOUT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NB-1:0]          proc_io_out,
    input  logic [NOUT-1:0]        proc_out_en,
    output logic [(NOUT-1)*NB-1:0] out_data,
    output logic [NOUT-2:0]        out_valid,
    input  logic [NOUT-2:0]        out_ready,
    output logic [NOUT-2:0]        overflow,
    output logic                   dec_err,
    input  logic                   err_clr
);
    logic [NOUT-2:0] push, pop, full, empty, drop, ovf_q, ovf_d;
    logic            onehot, bad, dec_q, dec_d;
    always_comb begin
        onehot = (proc_out_en & (proc_out_en - NOUT'(1))) == '0;
        bad    = (proc_out_en != '0) && (!onehot || proc_out_en[IN_PORT]);
        push   = bad ? '0 : proc_out_en[NOUT-1:FIRST_OUT_PORT];
        pop    = out_valid & out_ready;
        drop   = push & full & ~pop;
        ovf_d  = (err_clr ? '0 : ovf_q) | drop;
        dec_d  = (err_clr ? 1'b0 : dec_q) | bad;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            dec_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            dec_q <= dec_d;
        end
    end
    assign overflow  = ovf_q;
    assign dec_err   = dec_q;
    assign out_valid = ~empty;
    for (genvar g = 0; g < NOUT - 1; g++) begin : g_port
        out_port_fifo #(.NB(NB), .DEPTH(DEPTH)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push_i (push[g]),
            .data_i (proc_io_out),
            .pop_i  (pop[g]),
            .full_o (full[g]),
            .empty_o(empty[g]),
            .head_o (out_data[g*NB +: NB])
        );
    end
endmodule

// File: tb/tb_proc_out_collector.sv
// tb_proc_out_collector: directed self-checking bench for proc_out_collector
module tb_proc_out_collector;
    localparam int NB = 32;
    localparam int NOUT = 7;
    logic                   clk = 1'b0;
    logic                   rst;
    logic [NB-1:0]          proc_io_out;
    logic [NOUT-1:0]        proc_out_en;
    logic [(NOUT-1)*NB-1:0] out_data;
    logic [NOUT-2:0]        out_valid, out_ready, overflow;
    logic                   dec_err, err_clr;
    int n_cmp = 0;
    int n_err = 0;

    proc_out_collector #(.NB(NB), .NOUT(NOUT), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .proc_io_out(proc_io_out), .proc_out_en(proc_out_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .dec_err(dec_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [NB-1:0] sl(input int p);
        return out_data[p*NB +: NB];
    endfunction

    task automatic test_reset();
        rst = 1'b1; err_clr = 1'b0; out_ready = '1; proc_io_out = 32'd42; proc_out_en = 7'd2;
        tick(); tick();
        n_cmp++; if (out_valid !== 6'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", out_data); end
        n_cmp++; if (overflow !== 6'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        n_cmp++; if (dec_err !== 1'b0) begin n_err++; $display("FAIL reset_decerr got=%b exp=0", dec_err); end
        rst = 1'b0; proc_out_en = '0;
        tick();
        n_cmp++; if (out_valid !== 6'b0) begin n_err++; $display("FAIL reset_strobe_ignored got=%b exp=0", out_valid); end
    endtask

    task automatic test_single();
        out_ready = '1; proc_out_en = 7'd2; proc_io_out = -32'sd5;
        tick();
        proc_out_en = '0;
        n_cmp++; if (out_valid !== 6'b000001) begin n_err++; $display("FAIL single_valid got=%b exp=000001", out_valid); end
        n_cmp++; if (sl(0) !== -32'sd5) begin n_err++; $display("FAIL single_data got=%0d exp=-5", sl(0)); end
        n_cmp++; if (out_data[(NOUT-1)*NB-1:NB] !== '0) begin n_err++; $display("FAIL single_others got=%h exp=0", out_data[(NOUT-1)*NB-1:NB]); end
        tick();
        n_cmp++; if (out_valid !== 6'b0) begin n_err++; $display("FAIL single_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = '1;
        for (int i = 1; i <= 3; i++) begin
            proc_out_en = 7'd2; proc_io_out = 32'(i * 100);
            tick();
            n_cmp++; if (out_valid[0] !== 1'b1 || sl(0) !== 32'(i * 100)) begin n_err++; $display("FAIL b2b_%0d got valid=%b data=%0d exp valid=1 data=%0d", i, out_valid[0], sl(0), i * 100); end
        end
        proc_out_en = '0;
        tick();
        n_cmp++; if (out_valid !== 6'b0) begin n_err++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = '0;
        for (int i = 0; i < 5; i++) begin
            proc_out_en = 7'd8; proc_io_out = 32'(10 + i);
            tick();
        end
        proc_out_en = '0;
        n_cmp++; if (overflow !== 6'b000100) begin n_err++; $display("FAIL ovf_flag got=%b exp=000100", overflow); end
        out_ready = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid[2] !== 1'b1 || sl(2) !== 32'(10 + i)) begin n_err++; $display("FAIL ovf_drain_%0d got valid=%b data=%0d exp valid=1 data=%0d", i, out_valid[2], sl(2), 10 + i); end
            tick();
        end
        n_cmp++; if (out_valid[2] !== 1'b0 || sl(2) !== 32'sd0) begin n_err++; $display("FAIL ovf_empty got valid=%b data=%0d exp valid=0 data=0", out_valid[2], sl(2)); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (overflow !== 6'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_pop();
        int exp_q [4] = '{21, 22, 23, 99};
        out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            proc_out_en = 7'd64; proc_io_out = 32'(20 + i);
            tick();
        end
        proc_out_en = 7'd64; proc_io_out = 32'd99; out_ready = 6'b100000;
        tick();
        proc_out_en = '0;
        n_cmp++; if (overflow !== 6'b0) begin n_err++; $display("FAIL fullpop_ovf got=%b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid[5] !== 1'b1 || sl(5) !== 32'(exp_q[i])) begin n_err++; $display("FAIL fullpop_drain_%0d got valid=%b data=%0d exp valid=1 data=%0d", i, out_valid[5], sl(5), exp_q[i]); end
            tick();
        end
        n_cmp++; if (out_valid[5] !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got=%b exp=0", out_valid[5]); end
    endtask

    task automatic test_dec_err();
        out_ready = '0; proc_io_out = 32'd7;
        proc_out_en = 7'd6;
        tick();
        n_cmp++; if (dec_err !== 1'b1 || out_valid !== 6'b0) begin n_err++; $display("FAIL decerr_6 got dec=%b valid=%b exp dec=1 valid=0", dec_err, out_valid); end
        proc_out_en = 7'd1;
        tick();
        n_cmp++; if (dec_err !== 1'b1 || out_valid !== 6'b0) begin n_err++; $display("FAIL decerr_1 got dec=%b valid=%b exp dec=1 valid=0", dec_err, out_valid); end
        proc_out_en = '0; err_clr = 1'b1;
        tick();
        n_cmp++; if (dec_err !== 1'b0) begin n_err++; $display("FAIL decerr_clear got=%b exp=0", dec_err); end
        proc_out_en = 7'd3;
        tick();
        n_cmp++; if (dec_err !== 1'b1 || out_valid !== 6'b0) begin n_err++; $display("FAIL decerr_setwins got dec=%b valid=%b exp dec=1 valid=0", dec_err, out_valid); end
        proc_out_en = '0;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (dec_err !== 1'b0) begin n_err++; $display("FAIL decerr_reclear got=%b exp=0", dec_err); end
    endtask

    task automatic test_interleave();
        logic [NOUT-1:0] ens [4] = '{7'd2, 7'd4, 7'd2, 7'd64};
        out_ready = '0;
        for (int i = 0; i < 4; i++) begin
            proc_out_en = ens[i]; proc_io_out = 32'(i + 1);
            tick();
        end
        proc_out_en = '0;
        n_cmp++; if (out_valid !== 6'b100011) begin n_err++; $display("FAIL inter_valid got=%b exp=100011", out_valid); end
        n_cmp++; if (sl(0) !== 32'sd1 || sl(1) !== 32'sd2 || sl(5) !== 32'sd4) begin n_err++; $display("FAIL inter_heads got p1=%0d p2=%0d p6=%0d exp 1 2 4", sl(0), sl(1), sl(5)); end
        out_ready = '1;
        tick();
        n_cmp++; if (out_valid !== 6'b000001 || sl(0) !== 32'sd3) begin n_err++; $display("FAIL inter_second got valid=%b p1=%0d exp valid=000001 p1=3", out_valid, sl(0)); end
        tick();
        n_cmp++; if (out_valid !== 6'b0) begin n_err++; $display("FAIL inter_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            proc_out_en = 7'd4; proc_io_out = 32'(7 + i);
            tick();
        end
        n_cmp++; if (out_valid !== 6'b000010 || sl(1) !== 32'sd7) begin n_err++; $display("FAIL rstmid_pre got valid=%b p2=%0d exp valid=000010 p2=7", out_valid, sl(1)); end
        rst = 1'b1; proc_out_en = 7'd4; proc_io_out = 32'd77;
        tick();
        rst = 1'b0; proc_out_en = '0;
        n_cmp++; if (out_valid !== 6'b0 || out_data !== '0) begin n_err++; $display("FAIL rstmid_flush got valid=%b data=%h exp 0", out_valid, out_data); end
        proc_out_en = 7'd4; proc_io_out = 32'd55;
        tick();
        proc_out_en = '0;
        n_cmp++; if (out_valid !== 6'b000010 || sl(1) !== 32'sd55) begin n_err++; $display("FAIL rstmid_after got valid=%b p2=%0d exp valid=000010 p2=55", out_valid, sl(1)); end
        out_ready = '1;
        tick();
        n_cmp++; if (out_valid !== 6'b0) begin n_err++; $display("FAIL rstmid_drained got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_dec_err();
        test_interleave();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
